// File: rtl/fixed_norm_vec_pkg.sv
// fixed_norm_vec_pkg
// Shared types and helpers for the fixed-point normalised vector pipeline.
//   vop_e        : operation codes (5..7 reserved, carried as raw values)
//   stage_ctl_t  : per-stage control word (valid, op, error flag)
//   acc_w()      : internal accumulator width for a given lane width / lane count
//   sat_clamp()  : clamp a wide signed value into a w-bit signed range
//   sat_hit()    : 1 when sat_clamp() would change the value
package fixed_norm_vec_pkg;

  typedef enum logic [2:0] {
    VOP_DOT   = 3'd0,
    VOP_CROSS = 3'd1,
    VOP_ADD   = 3'd2,
    VOP_SUB   = 3'd3,
    VOP_SCALE = 3'd4
  } vop_e;

  typedef struct packed {
    logic vld;
    vop_e op;
    logic err;
  } stage_ctl_t;

  // Two guard bits cover |a*b| <= 4 and cross differences; clog2(DIM) covers the dot sum.
  function automatic int acc_w(input int width, input int dim);
    return width + 2 + $clog2(dim);
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x, input int w);
    return (sat_clamp(x, w) != x);
  endfunction

endpackage

// File: rtl/fixed_norm_mac_lane.sv
// fixed_norm_mac_lane
// One vector lane: S1 multiply (two products so cross fits in one lane),
// S2 round/align and lane-local combine, S3 saturate.
//   clk, reset          : clock, synchronous active-high reset
//   ld1_i/ld2_i/ld3_i   : stage load enables (stage holds when low)
//   op_in_i             : op of the beat entering S1 (selects product vs. pass-through)
//   op_s1_i             : op of the beat held in S1 (selects the S2 combine)
//   x0_i,y0_i,x1_i,y1_i : multiplier operands (x0/x1 are the raw operands for ADD/SUB)
//   acc2_o              : S2 result at ACC_W, exported for the dot tree
//   acc3_i              : value to saturate into S3 (chosen by the top)
//   res_o, sat_o        : saturated lane result and clamp flag
module fixed_norm_mac_lane
  import fixed_norm_vec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld1_i,
  input  logic                    ld2_i,
  input  logic                    ld3_i,
  input  vop_e                    op_in_i,
  input  vop_e                    op_s1_i,
  input  logic signed [WIDTH-1:0] x0_i,
  input  logic signed [WIDTH-1:0] y0_i,
  input  logic signed [WIDTH-1:0] x1_i,
  input  logic signed [WIDTH-1:0] y1_i,
  output logic signed [ACC_W-1:0] acc2_o,
  input  logic signed [ACC_W-1:0] acc3_i,
  output logic signed [WIDTH-1:0] res_o,
  output logic                    sat_o
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] RND = PW'(longint'(1) << (FRAC - 1));

  logic signed [PW-1:0]    p0_q, p0_d, p1_q, p1_d;
  logic signed [PW-1:0]    x0e, y0e, x1e, y1e;
  logic signed [ACC_W-1:0] acc2_q, acc2_d, r0, r1;
  logic signed [WIDTH-1:0] res_q, res_d;
  logic                    sat_q, sat_d;
  logic signed [63:0]      acc3_x;

  // S1: full-precision products, or sign-extended operands for ADD/SUB.
  always_comb begin
    x0e  = {{WIDTH{x0_i[WIDTH-1]}}, x0_i};
    y0e  = {{WIDTH{y0_i[WIDTH-1]}}, y0_i};
    x1e  = {{WIDTH{x1_i[WIDTH-1]}}, x1_i};
    y1e  = {{WIDTH{y1_i[WIDTH-1]}}, y1_i};
    p0_d = x0e * y0e;
    p1_d = x1e * y1e;
    if (op_in_i == VOP_ADD || op_in_i == VOP_SUB) begin
      p0_d = x0e;
      p1_d = x1e;
    end
  end

  // S2: round half up, then combine.
  always_comb begin
    r0 = ACC_W'((p0_q + RND) >>> FRAC);
    r1 = ACC_W'((p1_q + RND) >>> FRAC);
    case (op_s1_i)
      VOP_ADD:   acc2_d = ACC_W'(p0_q + p1_q);
      VOP_SUB:   acc2_d = ACC_W'(p0_q - p1_q);
      VOP_CROSS: acc2_d = r0 - r1;
      default:   acc2_d = r0;
    endcase
  end

  // S3: saturate to the lane width.
  always_comb begin
    acc3_x = {{(64 - ACC_W){acc3_i[ACC_W-1]}}, acc3_i};
    res_d  = WIDTH'(sat_clamp(acc3_x, WIDTH));
    sat_d  = sat_hit(acc3_x, WIDTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_q   <= '0;
      p1_q   <= '0;
      acc2_q <= '0;
      res_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (ld1_i) begin
        p0_q <= p0_d;
        p1_q <= p1_d;
      end
      if (ld2_i) acc2_q <= acc2_d;
      if (ld3_i) begin
        res_q <= res_d;
        sat_q <= sat_d;
      end
    end
  end

  assign acc2_o = acc2_q;
  assign res_o  = res_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/fixed_norm_vec_pipe.sv
// fixed_norm_vec_pipe
// 3-stage fixed-point vector unit (DOT, CROSS, ADD, SUB, SCALE) with
// valid/ready handshake and full back-pressure.
//   clk, reset                  : clock, synchronous active-high reset
//   in_valid/in_ready           : input handshake
//   in_op, in_a, in_b, in_s     : op code, vectors (lane d at [d*WIDTH +: WIDTH]), scalar
//   in_tag                      : opaque sideband, echoed on out_tag
//   out_valid/out_ready         : output handshake
//   out_v, out_sat, out_err     : result vector, per-lane clamp flags, error flag
//   out_tag                     : tag of the result beat
// The whole pipe advances in lockstep unless the output is stalled, so at
// most three beats are ever in flight and bubbles are never squeezed out.
module fixed_norm_vec_pipe
  import fixed_norm_vec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int DIM   = 3,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [DIM*WIDTH-1:0]   in_a,
  input  logic [DIM*WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]       in_s,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIM*WIDTH-1:0]   out_v,
  output logic [DIM-1:0]         out_sat,
  output logic                   out_err,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int ACC_W = acc_w(WIDTH, DIM);
  localparam int P     = 1 << $clog2(DIM);

  stage_ctl_t             c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [TAG_W-1:0]       tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic                   stall, accept, ld2, ld3, err_in;
  vop_e                   op_in;

  logic [DIM-1:0][WIDTH-1:0] a_l, b_l, res;
  logic [DIM-1:0][ACC_W-1:0] acc2, acc3;
  logic [DIM-1:0]            sat;
  logic signed [ACC_W-1:0]   dot_sum;

  assign a_l = in_a;
  assign b_l = in_b;

  // in_ready depends only on registered state and out_ready.
  assign stall    = c3_q.vld & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign ld2      = ~stall & c1_q.vld;
  assign ld3      = ~stall & c2_q.vld;

  assign op_in  = vop_e'(in_op);
  assign err_in = (in_op > 3'd4) || (op_in == VOP_CROSS && DIM != 3);

  always_comb begin
    c1_d   = c1_q;
    c2_d   = c2_q;
    c3_d   = c3_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    tag3_d = tag3_q;
    if (!stall) begin
      c1_d.vld = accept;
      if (accept) begin
        c1_d.op  = op_in;
        c1_d.err = err_in;
        tag1_d   = in_tag;
      end
      c2_d.vld = c1_q.vld;
      if (c1_q.vld) begin
        c2_d   = c1_q;
        tag2_d = tag1_q;
      end
      c3_d.vld = c2_q.vld;
      if (c2_q.vld) begin
        c3_d   = c2_q;
        tag3_d = tag2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c1_q   <= '0;
      c2_q   <= '0;
      c3_q   <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
    end else begin
      c1_q   <= c1_d;
      c2_q   <= c2_d;
      c3_q   <= c3_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      tag3_q <= tag3_d;
    end
  end

  // Balanced dot-product tree over the S2 lane results, padded to a power of two.
  always_comb begin : dot_tree
    logic signed [ACC_W-1:0] t [2*P];
    for (int i = 0; i < 2*P; i++) t[i] = '0;
    for (int i = 0; i < DIM; i++) t[P+i] = acc2[i];
    for (int k = P - 1; k >= 1; k--) t[k] = t[2*k] + t[2*k+1];
    dot_sum = t[1];
  end

  // S3 operand per lane: errors and non-zero DOT lanes are forced to 0.
  always_comb begin
    for (int d = 0; d < DIM; d++) begin
      acc3[d] = '0;
      if (!c2_q.err) begin
        if (c2_q.op == VOP_DOT) begin
          if (d == 0) acc3[d] = dot_sum;
        end else begin
          acc3[d] = acc2[d];
        end
      end
    end
  end

  for (genvar d = 0; d < DIM; d++) begin : g_lane
    // Cross lane d = a[d+1]*b[d+2] - a[d+2]*b[d+1] (indices mod 3).
    localparam int I1 = (d + 1) % DIM;
    localparam int I2 = (d + 2) % DIM;
    logic signed [WIDTH-1:0] x0, y0, x1, y1;

    always_comb begin
      x0 = $signed(a_l[d]);
      y0 = $signed(b_l[d]);
      x1 = '0;
      y1 = '0;
      case (op_in)
        VOP_CROSS: begin
          x0 = $signed(a_l[I1]);
          y0 = $signed(b_l[I2]);
          x1 = $signed(a_l[I2]);
          y1 = $signed(b_l[I1]);
        end
        VOP_SCALE: begin
          x0 = $signed(in_s);
          y0 = $signed(a_l[d]);
        end
        VOP_ADD, VOP_SUB: begin
          x0 = $signed(a_l[d]);
          x1 = $signed(b_l[d]);
        end
        default: ;
      endcase
    end

    fixed_norm_mac_lane #(
      .WIDTH(WIDTH),
      .FRAC (FRAC),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .ld1_i  (accept),
      .ld2_i  (ld2),
      .ld3_i  (ld3),
      .op_in_i(op_in),
      .op_s1_i(c1_q.op),
      .x0_i   (x0),
      .y0_i   (y0),
      .x1_i   (x1),
      .y1_i   (y1),
      .acc2_o (acc2[d]),
      .acc3_i (acc3[d]),
      .res_o  (res[d]),
      .sat_o  (sat[d])
    );
  end

  assign out_valid = c3_q.vld;
  assign out_err   = c3_q.err;
  assign out_tag   = tag3_q;
  assign out_v     = res;
  assign out_sat   = sat;

endmodule

// File: tb/tb_fixed_norm_vec_pipe.sv
module tb_fixed_norm_vec_pipe;

  localparam int WIDTH = 16;
  localparam int FRAC  = 14;
  localparam int DIM   = 3;
  localparam int TAG_W = 8;
  localparam int VW    = DIM * WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]       in_op;
  logic [VW-1:0]    in_a, in_b, out_v;
  logic [WIDTH-1:0] in_s;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [DIM-1:0]   out_sat;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [VW-1:0]    v;
    logic [DIM-1:0]   sat;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  fixed_norm_vec_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .DIM(DIM), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_v(out_v), .out_sat(out_sat), .out_err(out_err), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic longint lane_of(input logic [VW-1:0] v, input int d);
    logic [WIDTH-1:0] t;
    t = v[d*WIDTH +: WIDTH];
    return longint'($signed(t));
  endfunction

  function automatic longint fx_round(input longint p);
    return (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
  endfunction

  function automatic exp_t model(input int op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input logic [WIDTH-1:0] s, input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint r [DIM];
    longint hi, lo, c;
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -(longint'(1) << (WIDTH - 1));
    e.v = '0; e.sat = '0; e.tag = tag;
    e.err = (op > 4) || (op == 1 && DIM != 3);
    for (int d = 0; d < DIM; d++) r[d] = 0;
    if (!e.err) begin
      for (int d = 0; d < DIM; d++) begin
        case (op)
          0: r[0] += fx_round(lane_of(a, d) * lane_of(b, d));
          1: r[d] = fx_round(lane_of(a, (d+1)%3) * lane_of(b, (d+2)%3))
                  - fx_round(lane_of(a, (d+2)%3) * lane_of(b, (d+1)%3));
          2: r[d] = lane_of(a, d) + lane_of(b, d);
          3: r[d] = lane_of(a, d) - lane_of(b, d);
          default: r[d] = fx_round(longint'($signed(s)) * lane_of(a, d));
        endcase
      end
      for (int d = 0; d < DIM; d++) begin
        c = (r[d] > hi) ? hi : (r[d] < lo) ? lo : r[d];
        e.sat[d] = (c != r[d]);
        e.v[d*WIDTH +: WIDTH] = WIDTH'(c);
      end
    end
    return e;
  endfunction

  // Drive one beat with out_ready held high and report what came out.
  task automatic send_one(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [WIDTH-1:0] s, input logic [TAG_W-1:0] tag,
                          output int lat, output logic [VW-1:0] v, output logic [DIM-1:0] sat,
                          output logic err, output logic [TAG_W-1:0] otag);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_s = s; in_tag = tag; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    v = out_v; sat = out_sat; err = out_err; otag = out_tag;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_s = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    n_cmp += 6;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    if (out_v !== '0)       begin n_bad++; $display("FAIL reset out_v: got %h want 0", out_v); end
    if (out_sat !== '0)     begin n_bad++; $display("FAIL reset out_sat: got %b want 0", out_sat); end
    if (out_err !== 1'b0)   begin n_bad++; $display("FAIL reset out_err: got %b want 0", out_err); end
    if (out_tag !== '0)     begin n_bad++; $display("FAIL reset out_tag: got %h want 0", out_tag); end
    if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_dot();
    int lat; logic [VW-1:0] v; logic [DIM-1:0] sat; logic err; logic [TAG_W-1:0] tg;
    send_one(3'd0, {3{16'h2000}}, {3{16'h4000}}, 16'h0, 8'h5A, lat, v, sat, err, tg);
    n_cmp += 4;
    if (lat !== 3) begin n_bad++; $display("FAIL dot latency: got %0d want 3", lat); end
    if (v !== {16'h0, 16'h0, 16'h6000}) begin n_bad++; $display("FAIL dot value: got %h want 000000006000", v); end
    if (sat !== 3'b000 || err !== 1'b0) begin n_bad++; $display("FAIL dot flags: got sat=%b err=%b want 000/0", sat, err); end
    if (tg !== 8'h5A) begin n_bad++; $display("FAIL dot tag: got %h want 5a", tg); end
  endtask

  task automatic test_cross();
    int lat; logic [VW-1:0] v; logic [DIM-1:0] sat; logic err; logic [TAG_W-1:0] tg;
    send_one(3'd1, {16'h0, 16'h0, 16'h4000}, {16'h0, 16'h4000, 16'h0}, 16'h0, 8'h11, lat, v, sat, err, tg);
    n_cmp += 2;
    if (v !== {16'h4000, 16'h0, 16'h0}) begin n_bad++; $display("FAIL cross value: got %h want 400000000000", v); end
    if (sat !== 3'b000 || err !== 1'b0 || lat !== 3) begin
      n_bad++; $display("FAIL cross flags: got sat=%b err=%b lat=%0d want 000/0/3", sat, err, lat);
    end
  endtask

  task automatic test_saturation();
    int lat; logic [VW-1:0] v; logic [DIM-1:0] sat; logic err; logic [TAG_W-1:0] tg;
    send_one(3'd0, {3{16'h8000}}, {3{16'h8000}}, 16'h0, 8'h21, lat, v, sat, err, tg);
    n_cmp += 2;
    if (v !== {16'h0, 16'h0, 16'h7FFF}) begin n_bad++; $display("FAIL sat dot value: got %h want 000000007fff", v); end
    if (sat !== 3'b001) begin n_bad++; $display("FAIL sat dot flag: got %b want 001", sat); end
    send_one(3'd2, {16'h0, 16'h0, 16'h7000}, {16'h0, 16'h0, 16'h7000}, 16'h0, 8'h22, lat, v, sat, err, tg);
    n_cmp += 2;
    if (v !== {16'h0, 16'h0, 16'h7FFF}) begin n_bad++; $display("FAIL sat add value: got %h want 000000007fff", v); end
    if (sat !== 3'b001) begin n_bad++; $display("FAIL sat add flag: got %b want 001", sat); end
  endtask

  task automatic test_rounding();
    int lat; logic [VW-1:0] v; logic [DIM-1:0] sat; logic err; logic [TAG_W-1:0] tg;
    send_one(3'd4, {16'h0, 16'h0, 16'h2000}, '0, 16'h0001, 8'h31, lat, v, sat, err, tg);
    n_cmp++;
    if (v !== {16'h0, 16'h0, 16'h0001}) begin n_bad++; $display("FAIL round up: got %h want 000000000001", v); end
    send_one(3'd4, {16'h0, 16'h0, 16'h1FFF}, '0, 16'h0001, 8'h32, lat, v, sat, err, tg);
    n_cmp++;
    if (v !== '0) begin n_bad++; $display("FAIL round down: got %h want 0", v); end
  endtask

  task automatic test_error();
    int lat; logic [VW-1:0] v; logic [DIM-1:0] sat; logic err; logic [TAG_W-1:0] tg;
    send_one(3'd5, {3{16'h2000}}, {3{16'h4000}}, 16'h1234, 8'h41, lat, v, sat, err, tg);
    n_cmp += 2;
    if (err !== 1'b1 || lat !== 3) begin n_bad++; $display("FAIL error flag: got err=%b lat=%0d want 1/3", err, lat); end
    if (v !== '0 || sat !== '0 || tg !== 8'h41) begin
      n_bad++; $display("FAIL error data: got v=%h sat=%b tag=%h want 0/000/41", v, sat, tg);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd2; in_a = {3{16'h0100}}; in_b = {3{16'h0100}}; in_tag = 8'(8'h60 + i);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset flush: got out_valid=%b want 0", out_valid); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL stale after reset: got %0d beats want 0", seen); end
  endtask

  // Streamed random beats; bp randomises out_ready, gaps randomises in_valid.
  task automatic test_stream(input string name, input int n, input bit bp, input bit gaps);
    exp_t             q [$];
    exp_t             e;
    int               sent = 0, got = 0, cyc = 0;
    bit               stalled = 0;
    logic [VW-1:0]    sv_v;
    logic [DIM-1:0]   sv_sat;
    logic             sv_err;
    logic [TAG_W-1:0] sv_tag;
    while ((sent < n || got < n) && cyc < n * 20 + 50) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_v !== sv_v || out_sat !== sv_sat || out_err !== sv_err || out_tag !== sv_tag) begin
          n_bad++;
          $display("FAIL %s stall stability: got vld=%b v=%h sat=%b err=%b tag=%h want 1 %h %b %b %h",
                   name, out_valid, out_v, out_sat, out_err, out_tag, sv_v, sv_sat, sv_err, sv_tag);
        end
      end
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (sent < n && (!gaps || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_op    = 3'($urandom_range(0, 7));
        in_a     = VW'({$urandom, $urandom});
        in_b     = VW'({$urandom, $urandom});
        in_s     = WIDTH'($urandom);
        in_tag   = TAG_W'(sent + 8'h80);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_bad++; $display("FAIL %s in_ready: got %b want %b", name, in_ready, !(out_valid && !out_ready));
      end
      if (in_valid && in_ready) begin
        q.push_back(model(int'(in_op), in_a, in_b, in_s, in_tag));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL %s unexpected beat: got tag=%h want none", name, out_tag);
        end else begin
          e = q.pop_front();
          if (out_v !== e.v || out_sat !== e.sat || out_err !== e.err || out_tag !== e.tag) begin
            n_bad++;
            $display("FAIL %s beat %0d: got v=%h sat=%b err=%b tag=%h want v=%h sat=%b err=%b tag=%h",
                     name, got, out_v, out_sat, out_err, out_tag, e.v, e.sat, e.err, e.tag);
          end
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      sv_v = out_v; sv_sat = out_sat; sv_err = out_err; sv_tag = out_tag;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got != n || sent != n || q.size() != 0) begin
      n_bad++; $display("FAIL %s count: got sent=%0d recv=%0d left=%0d want %0d/%0d/0", name, sent, got, q.size(), n, n);
    end
  endtask

  initial begin
    test_reset();
    test_dot();
    test_cross();
    test_saturation();
    test_rounding();
    test_error();
    test_stream("back_pressure", 10, 1'b1, 1'b0);
    test_stream("back_to_back", 40, 1'b0, 1'b0);
    test_stream("random", 300, 1'b1, 1'b1);
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
